// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-8 registered write demux.
// Read-back port is enabled by defining DEMUX_READBACK_EN (see top).
package demux_pkg;
  localparam int NOUT  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/demux_burst_ctrl.sv
// Burst sequencer: IDLE/BURST/DONE FSM plus 3-bit word pointer.
// Emits the burst write strobe/index and the single-write permission.
module demux_burst_ctrl
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             burst_start,
  input  logic             burst_valid,
  output logic             busy,
  output logic             done,
  output logic             bwr,
  output logic [SEL_W-1:0] bidx,
  output logic             swr,
  output logic [1:0]       state_dbg
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NOUT - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    bwr       = 1'b0;
    swr       = 1'b0;
    case (state)
      S_IDLE: begin
        // burst_start takes priority over a simultaneous single write
        if (burst_start) begin
          state_nxt = S_BURST;
          ptr_nxt   = '0;
        end else begin
          swr = wr_en;
        end
      end
      S_BURST: begin
        if (burst_valid) begin
          bwr     = 1'b1;
          ptr_nxt = ptr + SEL_W'(1);
          if (ptr == LAST_IDX) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bidx      = ptr;
  assign busy      = (state == S_BURST);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: rtl/demux32_1x8_reg.sv
// Routes a 32-bit write into one of eight destination registers, by sel or by burst.
// Optional registered read-back port when DEMUX_READBACK_EN is defined.
module demux32_1x8_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef DEMUX_READBACK_EN
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data,
`endif
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  input  logic             wr_en,
  input  logic             burst_start,
  input  logic             burst_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_h,
  output logic [NOUT-1:0]  written,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  logic [WIDTH-1:0] dst [NOUT];
  logic             bwr, swr, wr;
  logic [SEL_W-1:0] bidx, wr_idx;
  logic [NOUT-1:0]  wr_mask;

  demux_burst_ctrl u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .burst_start (burst_start),
    .burst_valid (burst_valid),
    .busy        (busy),
    .done        (done),
    .bwr         (bwr),
    .bidx        (bidx),
    .swr         (swr),
    .state_dbg   (fsm_state)
  );

  assign wr      = bwr | swr;
  assign wr_idx  = bwr ? bidx : sel;
  assign wr_mask = wr ? ({{(NOUT-1){1'b0}}, 1'b1} << wr_idx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NOUT; i++) dst[i] <= '0;
      written <= '0;
    end else begin
      if (wr) dst[wr_idx] <= in;
      // a bit written in the same cycle as clr survives the clear
      written <= (clr ? '0 : written) | wr_mask;
    end
  end

`ifdef DEMUX_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= dst[rd_sel];
  end
`endif

  assign out_a = dst[0];
  assign out_b = dst[1];
  assign out_c = dst[2];
  assign out_d = dst[3];
  assign out_e = dst[4];
  assign out_f = dst[5];
  assign out_g = dst[6];
  assign out_h = dst[7];

endmodule

// File: tb/tb_demux32_1x8_reg.sv
// Directed bench for demux32_1x8_reg: single writes, bursts, ignored inputs, clr, async reset.
// Read-back checks are included when DEMUX_READBACK_EN is defined.
module tb_demux32_1x8_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in;
  logic [2:0]  sel;
  logic        wr_en, burst_start, burst_valid, clr;
  logic [31:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic [7:0]  written;
  logic        busy, done;
  logic [1:0]  fsm_state;
`ifdef DEMUX_READBACK_EN
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
`endif

  logic [31:0] outs [8];
  logic [31:0] exp_out [8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux32_1x8_reg dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef DEMUX_READBACK_EN
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
`endif
    .in          (in),
    .sel         (sel),
    .wr_en       (wr_en),
    .burst_start (burst_start),
    .burst_valid (burst_valid),
    .clr         (clr),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .out_e       (out_e),
    .out_f       (out_f),
    .out_g       (out_g),
    .out_h       (out_h),
    .written     (written),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;
  assign outs[3] = out_d;
  assign outs[4] = out_e;
  assign outs[5] = out_f;
  assign outs[6] = out_g;
  assign outs[7] = out_h;

  // advance one clock and land just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in = '0; sel = '0; wr_en = 0; burst_start = 0; burst_valid = 0; clr = 0;
`ifdef DEMUX_READBACK_EN
    rd_sel = '0;
`endif
    for (int i = 0; i < 8; i++) exp_out[i] = 32'h0;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 32'h0) begin failures++; $display("FAIL reset_out%0d got=%h exp=0", i, outs[i]); end
    end
    checks++;
    if (written !== 8'h00) begin failures++; $display("FAIL reset_written got=%h exp=00", written); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
      failures++; $display("FAIL reset_ctrl got busy=%b done=%b st=%0d exp 0 0 0", busy, done, fsm_state);
    end
`ifdef DEMUX_READBACK_EN
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    wr_en = 1; sel = 3'd5; in = 32'hDEADBEEF;
    step();
    wr_en = 0;
    exp_out[5] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== exp_out[i]) begin failures++; $display("FAIL single_out%0d got=%h exp=%h", i, outs[i], exp_out[i]); end
    end
    checks++;
    if (written !== 8'h20) begin failures++; $display("FAIL single_written got=%h exp=20", written); end
    wr_en = 1; sel = 3'd7; in = 32'h12345678;
    step();
    wr_en = 0;
    exp_out[7] = 32'h12345678;
    checks++;
    if (out_h !== 32'h12345678) begin failures++; $display("FAIL single_out_h got=%h exp=12345678", out_h); end
    checks++;
    if (written !== 8'hA0) begin failures++; $display("FAIL single_written2 got=%h exp=a0", written); end
  endtask

`ifdef DEMUX_READBACK_EN
  task automatic test_readback();
    rd_sel = 3'd5;
    step();
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rb_sel5 got=%h exp=deadbeef", rd_data); end
    rd_sel = 3'd7; wr_en = 1; sel = 3'd7; in = 32'hCAFEF00D;
    step();
    wr_en = 0;
    checks++;
    if (rd_data !== 32'h12345678) begin failures++; $display("FAIL rb_old got=%h exp=12345678", rd_data); end
    step();
    checks++;
    if (rd_data !== 32'hCAFEF00D) begin failures++; $display("FAIL rb_new got=%h exp=cafef00d", rd_data); end
    exp_out[7] = 32'hCAFEF00D;
  endtask
`endif

  task automatic test_burst();
    burst_start = 1;
    step();
    burst_start = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || fsm_state !== 2'd1) begin
      failures++; $display("FAIL burst_enter got busy=%b done=%b st=%0d exp 1 0 1", busy, done, fsm_state);
    end
    for (int i = 0; i < 8; i++) begin
      burst_valid = 1; in = 32'h100 + 32'(i);
      step();
      exp_out[i] = 32'h100 + 32'(i);
      checks++;
      if (i < 7) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++; $display("FAIL burst_busy w%0d got busy=%b done=%b exp 1 0", i, busy, done);
        end
      end else if (busy !== 1'b0 || done !== 1'b1) begin
        failures++; $display("FAIL burst_done got busy=%b done=%b exp 0 1", busy, done);
      end
      if (i == 3) begin
        burst_valid = 0; in = 32'hBAD0BAD0;
        for (int k = 0; k < 2; k++) begin
          step();
          checks++;
          if (busy !== 1'b1 || out_e !== exp_out[4]) begin
            failures++; $display("FAIL burst_hold got busy=%b out_e=%h exp 1 %h", busy, out_e, exp_out[4]);
          end
        end
      end
    end
    burst_valid = 0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
      failures++; $display("FAIL burst_exit got busy=%b done=%b st=%0d exp 0 0 0", busy, done, fsm_state);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== exp_out[i]) begin failures++; $display("FAIL burst_out%0d got=%h exp=%h", i, outs[i], exp_out[i]); end
    end
    checks++;
    if (written !== 8'hFF) begin failures++; $display("FAIL burst_written got=%h exp=ff", written); end
  endtask

  task automatic test_ignored();
    burst_start = 1;
    step();
    // wr_en and burst_start held high through the burst must not disturb it
    wr_en = 1; sel = 3'd2;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        burst_valid = 0; in = 32'hBAD2BAD2;
        step();
      end
      burst_valid = 1; in = 32'h200 + 32'(i);
      step();
      exp_out[i] = 32'h200 + 32'(i);
    end
    burst_valid = 0; burst_start = 0;
    checks++;
    if (out_c !== 32'h202) begin failures++; $display("FAIL ign_burst_out_c got=%h exp=00000202", out_c); end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
    // inputs during the DONE cycle are ignored
    wr_en = 1; sel = 3'd4; in = 32'hBAD4BAD4;
    step();
    checks++;
    if (out_e !== 32'h204 || fsm_state !== 2'd0) begin
      failures++; $display("FAIL ign_done_write got out_e=%h st=%0d exp 00000204 0", out_e, fsm_state);
    end
    burst_start = 1; wr_en = 1; sel = 3'd1; in = 32'hBAD1BAD1;
    step();
    burst_start = 0; wr_en = 0;
    checks++;
    if (out_b !== 32'h201 || busy !== 1'b1) begin
      failures++; $display("FAIL ign_start_wins got out_b=%h busy=%b exp 00000201 1", out_b, busy);
    end
    for (int i = 0; i < 8; i++) begin
      burst_valid = 1; in = 32'h300 + 32'(i);
      step();
      exp_out[i] = 32'h300 + 32'(i);
    end
    burst_valid = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== exp_out[i]) begin failures++; $display("FAIL ign_out%0d got=%h exp=%h", i, outs[i], exp_out[i]); end
    end
  endtask

  task automatic test_clr();
    checks++;
    if (written !== 8'hFF) begin failures++; $display("FAIL clr_pre got=%h exp=ff", written); end
    clr = 1; wr_en = 1; sel = 3'd0; in = 32'h55;
    step();
    clr = 0; wr_en = 0;
    checks++;
    if (written !== 8'h01) begin failures++; $display("FAIL clr_with_write got=%h exp=01", written); end
    checks++;
    if (out_a !== 32'h55 || out_h !== 32'h307) begin
      failures++; $display("FAIL clr_outs got out_a=%h out_h=%h exp 00000055 00000307", out_a, out_h);
    end
    clr = 1;
    step();
    clr = 0;
    checks++;
    if (written !== 8'h00) begin failures++; $display("FAIL clr_only got=%h exp=00", written); end
  endtask

  task automatic test_reset_mid();
    burst_start = 1;
    step();
    burst_start = 0;
    burst_valid = 1; in = 32'h400; step();
    in = 32'h401; step();
    burst_valid = 0;
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 32'h0) begin failures++; $display("FAIL arst_out%0d got=%h exp=0", i, outs[i]); end
    end
    checks++;
    if (written !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
      failures++; $display("FAIL arst_ctrl got wr=%h busy=%b done=%b st=%0d exp 00 0 0 0", written, busy, done, fsm_state);
    end
    step();
    reset_n = 1'b1;
    wr_en = 1; sel = 3'd3; in = 32'h77;
    step();
    wr_en = 0;
    checks++;
    if (out_d !== 32'h77 || written !== 8'h08 || busy !== 1'b0) begin
      failures++; $display("FAIL arst_after_write got out_d=%h wr=%h busy=%b exp 00000077 08 0", out_d, written, busy);
    end
    burst_start = 1; step(); burst_start = 0;
    burst_valid = 1; in = 32'h88; step(); burst_valid = 0;
    checks++;
    if (out_a !== 32'h88 || out_b !== 32'h0) begin
      failures++; $display("FAIL arst_ptr_restart got out_a=%h out_b=%h exp 00000088 0", out_a, out_b);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
`ifdef DEMUX_READBACK_EN
    test_readback();
`endif
    test_burst();
    test_ignored();
    test_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
